sc_core_oz_wb: RTL and testbench
================================

Name: sc_core_oz_wb

Overview:
- Write-back stage of the sc_core_oz single-cycle RV32I core; sits directly upstream of the register file and drives its write port (rd_reg_data, rd_reg_address, rd_wr_en).
- Registers ALU results for a 1-cycle write.
- Runs loads as multi-cycle transactions over a valid/ready data-memory request channel, then byte/half-extends the response.
- Stalls the PC while a load is outstanding.

Parameters:
- DATA_W, 32, datapath width (fixed 32 for RV32I).
- REG_AW, 5, register address width.

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- alu_valid  input  1  instruction retires this cycle from execute.
- alu_wr_en  input  1  instruction writes rd.
- alu_rd_addr  input  5  destination register.
- alu_result  input  32  ALU/JAL/LUI result.
- ld_req  input  1  retiring instruction is a load; overrides the alu path.
- ld_funct3  input  3  load type.
- ld_addr  input  32  effective load address.
- mem_req_valid  output  1  read request to data memory.
- mem_req_ready  input  1  memory accepts the request.
- mem_req_addr  output  32  word-aligned address {ld_addr[31:2],2'b00}.
- mem_rsp_valid  input  1  read data valid.
- mem_rsp_data  input  32  read word.
- stall  output  1  hold PC/fetch.
- rd_wr_en  output  1  RF write enable.
- rd_reg_address  output  5  RF write address.
- rd_reg_data  output  32  RF write data.

Behaviour:
- Reset:
  - Async assert forces state IDLE; all outputs and captured fields go to 0.
  - Applies at any point, including mid-load; a response arriving after reset release is ignored.
- FSM states: IDLE, REQ, WAIT, WRITE.
- IDLE:
  - alu_valid=1, ld_req=0, alu_wr_en=1, alu_rd_addr!=0: next cycle rd_wr_en=1, rd_reg_address=alu_rd_addr, rd_reg_data=alu_result. Latency 1; stays in IDLE.
  - alu_valid=1, ld_req=1: capture ld_funct3, ld_addr[1:0], ld_addr[31:2], alu_rd_addr; go to REQ. stall=1 combinationally in this same cycle.
- REQ: mem_req_valid=1, mem_req_addr held stable until mem_req_ready=1, then go to WAIT.
- WAIT:
  - On mem_rsp_valid=1: extract and extend, latch the result, go to WRITE.
  - mem_rsp_valid is ignored in every state other than WAIT; memory guarantees at least 1 cycle request-to-response.
- WRITE: rd_wr_en=1 for exactly 1 cycle with the latched data; go to IDLE.
- stall = (IDLE & alu_valid & ld_req) | REQ | WAIT | WRITE. The stall drops on the cycle the FSM returns to IDLE.
- While not in IDLE, alu_*/ld_* inputs are ignored; upstream holds them under stall.
- Extraction: byte select = offset[1:0]; half select = offset[1].
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - Other encodings are treated as LW.
- rd=0 rule: writes to x0 are suppressed (rd_wr_en=0) on both paths. A load to x0 still performs the memory transaction and stall sequence.
- rd_wr_en is 0 in every cycle not listed above.

Optional Feature:
- Macro: SC_CORE_OZ_WB_MISALIGN_EN.
- Defined:
  - Adds output misalign_err (1 bit, reset 0).
  - In IDLE, a load that is misaligned (LH/LHU with offset[0]=1, or LW with offset!=0) issues no memory request and performs no RF write.
  - misalign_err pulses 1 for one cycle (the next cycle), stall is 0, and the FSM stays in IDLE.
- Undefined:
  - No misalign_err port.
  - Low address bits beyond the select rules are ignored; the load completes normally.

Test Plan:
- ALU write: alu_valid=1, alu_wr_en=1, rd=5, result=0xDEADBEEF -> next cycle rd_wr_en=1, addr=5, data=0xDEADBEEF, stall=0 throughout.
- LB sign: ld_addr=0x103, rsp=0x80112233, ready immediate, rsp 2 cycles later -> stall high from request cycle until WRITE ends; mem_req_addr=0x100; rd_reg_data=0xFFFFFF80; exactly one rd_wr_en pulse.
- LHU/LH/LBU at offset 2, rsp=0xA5C3_0000 -> 0x0000A5C3 / 0xFFFFA5C3 / 0x000000C3.
- Backpressure: mem_req_ready low for 5 cycles -> mem_req_valid and mem_req_addr stable all 5 cycles; a spurious mem_rsp_valid during REQ is ignored.
- x0 and reset:
  - ALU write to rd=0 -> rd_wr_en stays 0.
  - Assert rst during WAIT -> outputs 0 immediately; a later mem_rsp_valid causes no write.
- Misalign (macro on): LW at 0x102 -> no mem_req_valid, misalign_err=1 for 1 cycle, no write. Macro off: same load returns the full word from 0x100.

Source files
------------

// File: rtl/sc_core_oz_wb.sv
`default_nettype none
// ============================================================================
// Module   : sc_core_oz_wb
// Purpose  : Write-back stage of the sc_core_oz single-cycle RV32I core.
//            ALU results are registered and written to the register file
//            one cycle later. Loads run as a multi-cycle transaction on a
//            valid/ready data-memory channel. The returned word is then
//            byte/half extracted and extended, and written back in a
//            dedicated WRITE cycle. The PC is stalled while a load is in
//            flight.
// Ports    : clk, rst (async, active-low)
//            alu_valid/alu_wr_en/alu_rd_addr/alu_result  - execute retire
//            ld_req/ld_funct3/ld_addr                    - load request
//            mem_req_valid/mem_req_ready/mem_req_addr    - memory request
//            mem_rsp_valid/mem_rsp_data                  - memory response
//            stall                                       - hold PC/fetch
//            rd_wr_en/rd_reg_address/rd_reg_data         - RF write port
//            misalign_err (only with SC_CORE_OZ_WB_MISALIGN_EN)
// Options  : `define SC_CORE_OZ_WB_MISALIGN_EN to trap misaligned LH/LHU/LW
//            in IDLE instead of issuing them.
// Revision : 1.0 - initial release
// ============================================================================
module sc_core_oz_wb #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic              alu_wr_en,
  input  logic [REG_AW-1:0] alu_rd_addr,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              ld_req,
  input  logic [2:0]        ld_funct3,
  input  logic [DATA_W-1:0] ld_addr,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [DATA_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              stall,
`ifdef SC_CORE_OZ_WB_MISALIGN_EN
  output logic              misalign_err,
`endif
  output logic              rd_wr_en,
  output logic [REG_AW-1:0] rd_reg_address,
  output logic [DATA_W-1:0] rd_reg_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  logic [1:0]        state_q,   state_d;
  logic [2:0]        funct3_q,  funct3_d;
  logic [1:0]        off_q,     off_d;
  logic [DATA_W-3:0] addr_hi_q, addr_hi_d;
  logic [REG_AW-1:0] rd_q,      rd_d;
  logic              wr_en_q,   wr_en_d;
  logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic [DATA_W-1:0] w_shifted;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_ext;
  logic              w_ld_start;
  logic              w_ld_issue;

  assign w_ld_start = (state_q == S_IDLE) && alu_valid && ld_req;

`ifdef SC_CORE_OZ_WB_MISALIGN_EN
  logic misalign_q, misalign_d;
  logic w_misalign;

  // Encodings outside LB/LH/LBU/LHU behave as LW, so they need full alignment.
  always_comb begin
    case (ld_funct3)
      3'b000, 3'b100: w_misalign = 1'b0;
      3'b001, 3'b101: w_misalign = ld_addr[0];
      default:        w_misalign = (ld_addr[1:0] != 2'b00);
    endcase
  end

  assign w_ld_issue   = w_ld_start && !w_misalign;
  assign misalign_err = misalign_q;
`else
  assign w_ld_issue = w_ld_start;
`endif

  // Byte lane picked by the full offset, half lane by offset[1] only.
  assign w_shifted = mem_rsp_data >> {off_q, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = off_q[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];

  always_comb begin
    case (funct3_q)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_ext = {24'd0, w_byte};
      3'b101:  w_ext = {16'd0, w_half};
      default: w_ext = mem_rsp_data;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    funct3_d  = funct3_q;
    off_d     = off_q;
    addr_hi_d = addr_hi_q;
    rd_d      = rd_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef SC_CORE_OZ_WB_MISALIGN_EN
    misalign_d = w_ld_start && w_misalign;
`endif
    case (state_q)
      S_IDLE: begin
        if (w_ld_issue) begin
          funct3_d  = ld_funct3;
          off_d     = ld_addr[1:0];
          addr_hi_d = ld_addr[DATA_W-1:2];
          rd_d      = alu_rd_addr;
          state_d   = S_REQ;
        end else if (alu_valid && !ld_req && alu_wr_en && (alu_rd_addr != '0)) begin
          wr_en_d   = 1'b1;
          wr_addr_d = alu_rd_addr;
          wr_data_d = alu_result;
        end
      end
      S_REQ: begin
        if (mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          // A load to x0 still walks through WRITE so the stall length is
          // identical; only the RF strobe is suppressed.
          if (rd_q != '0) begin
            wr_en_d   = 1'b1;
            wr_addr_d = rd_q;
            wr_data_d = w_ext;
          end
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      funct3_q  <= '0;
      off_q     <= '0;
      addr_hi_q <= '0;
      rd_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef SC_CORE_OZ_WB_MISALIGN_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      funct3_q  <= funct3_d;
      off_q     <= off_d;
      addr_hi_q <= addr_hi_d;
      rd_q      <= rd_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
`ifdef SC_CORE_OZ_WB_MISALIGN_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign mem_req_valid  = (state_q == S_REQ);
  assign mem_req_addr   = {addr_hi_q, 2'b00};
  assign stall          = w_ld_issue || (state_q != S_IDLE);
  assign rd_wr_en       = wr_en_q;
  assign rd_reg_address = wr_addr_q;
  assign rd_reg_data    = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_sc_core_oz_wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_sc_core_oz_wb
// Purpose  : Self-checking bench for sc_core_oz_wb. Directed scenarios plus
//            randomized ALU/load traffic compared against a transaction-level
//            reference model of load extraction and x0 suppression.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sc_core_oz_wb;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic        alu_wr_en;
  logic [4:0]  alu_rd_addr;
  logic [31:0] alu_result;
  logic        ld_req;
  logic [2:0]  ld_funct3;
  logic [31:0] ld_addr;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        stall;
  logic        rd_wr_en;
  logic [4:0]  rd_reg_address;
  logic [31:0] rd_reg_data;
`ifdef SC_CORE_OZ_WB_MISALIGN_EN
  logic        misalign_err;
`endif

  int total;
  int bad;

  sc_core_oz_wb #(.DATA_W(32), .REG_AW(5)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .alu_valid      (alu_valid),
    .alu_wr_en      (alu_wr_en),
    .alu_rd_addr    (alu_rd_addr),
    .alu_result     (alu_result),
    .ld_req         (ld_req),
    .ld_funct3      (ld_funct3),
    .ld_addr        (ld_addr),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .stall          (stall),
`ifdef SC_CORE_OZ_WB_MISALIGN_EN
    .misalign_err   (misalign_err),
`endif
    .rd_wr_en       (rd_wr_en),
    .rd_reg_address (rd_reg_address),
    .rd_reg_data    (rd_reg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: value written back for a load, from the ISA load rules.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] word);
    longint v;
    int unsigned off;
    off = addr % 4;
    case (f3)
      3'd0: begin v = (word >> (8 * off)) % 256;          if (v >= 128)   v -= 256;   end
      3'd1: begin v = (word >> (16 * (off / 2))) % 65536; if (v >= 32768) v -= 65536; end
      3'd4: v = (word >> (8 * off)) % 256;
      3'd5: v = (word >> (16 * (off / 2))) % 65536;
      default: v = word;
    endcase
    return v[31:0];
  endfunction

  function automatic bit ref_misaligned(input logic [2:0] f3, input logic [31:0] addr);
`ifdef SC_CORE_OZ_WB_MISALIGN_EN
    if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
    if (f3 == 3'd1 || f3 == 3'd5) return (addr % 2) != 0;
    return (addr % 4) != 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic idle_inputs();
    alu_valid   = 1'b0;
    ld_req      = 1'b0;
    alu_wr_en   = 1'b0;
    alu_rd_addr = 5'($urandom);
    alu_result  = $urandom;
    ld_funct3   = 3'($urandom);
    ld_addr     = $urandom;
  endtask

  task automatic alu_op(input logic [4:0] rd, input logic [31:0] res, input logic wr);
    bit exp_wr;
    exp_wr      = wr && (rd != 0);
    alu_valid   = 1'b1;
    ld_req      = 1'b0;
    alu_wr_en   = wr;
    alu_rd_addr = rd;
    alu_result  = res;
    #1;
    check("alu_stall_issue", 32'(stall), 32'd0);
    tick();
    idle_inputs();
    #1;
    check("alu_wr_en", 32'(rd_wr_en), 32'(exp_wr));
    if (exp_wr) begin
      check("alu_wr_addr", 32'(rd_reg_address), 32'(rd));
      check("alu_wr_data", rd_reg_data, res);
    end
    check("alu_stall_after", 32'(stall), 32'd0);
  endtask

  task automatic load_op(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                         input int ready_dly, input int rsp_dly, input logic [31:0] word,
                         input bit spur);
    logic [31:0] exp_addr;
    bit          mis;
    exp_addr    = addr & 32'hFFFF_FFFC;
    mis         = ref_misaligned(f3, addr);
    alu_valid   = 1'b1;
    ld_req      = 1'b1;
    alu_wr_en   = 1'($urandom);
    alu_rd_addr = rd;
    alu_result  = $urandom;
    ld_funct3   = f3;
    ld_addr     = addr;
    #1;
    check("ld_stall_issue", 32'(stall), 32'(!mis));
    check("ld_req_valid_idle", 32'(mem_req_valid), 32'd0);
    tick();
    idle_inputs();
    #1;
`ifdef SC_CORE_OZ_WB_MISALIGN_EN
    check("ld_misalign_err", 32'(misalign_err), 32'(mis));
`endif
    if (mis) begin
      check("mis_req_valid", 32'(mem_req_valid), 32'd0);
      check("mis_wr_en", 32'(rd_wr_en), 32'd0);
      check("mis_stall", 32'(stall), 32'd0);
      tick();
`ifdef SC_CORE_OZ_WB_MISALIGN_EN
      check("mis_err_pulse_end", 32'(misalign_err), 32'd0);
`endif
      check("mis_req_valid2", 32'(mem_req_valid), 32'd0);
      return;
    end
    for (int k = 0; k < ready_dly; k++) begin
      check("req_valid_bp", 32'(mem_req_valid), 32'd1);
      check("req_addr_bp", mem_req_addr, exp_addr);
      check("req_stall_bp", 32'(stall), 32'd1);
      check("req_wr_en_bp", 32'(rd_wr_en), 32'd0);
      mem_rsp_valid = spur && (k == 1);
      mem_rsp_data  = 32'hFFFF_FFFF;
      tick();
      mem_rsp_valid = 1'b0;
    end
    check("req_valid", 32'(mem_req_valid), 32'd1);
    check("req_addr", mem_req_addr, exp_addr);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int k = 0; k < rsp_dly; k++) begin
      check("wait_req_valid", 32'(mem_req_valid), 32'd0);
      check("wait_stall", 32'(stall), 32'd1);
      check("wait_wr_en", 32'(rd_wr_en), 32'd0);
      tick();
    end
    check("wait_stall_rsp", 32'(stall), 32'd1);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = word;
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = $urandom;
    check("wb_wr_en", 32'(rd_wr_en), 32'(rd != 0));
    if (rd != 0) begin
      check("wb_addr", 32'(rd_reg_address), 32'(rd));
      check("wb_data", rd_reg_data, ref_load(f3, addr, word));
    end
    check("wb_stall", 32'(stall), 32'd1);
    tick();
    check("post_wr_en", 32'(rd_wr_en), 32'd0);
    check("post_stall", 32'(stall), 32'd0);
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'd0;
    idle_inputs();
    #23;
    check("rst_wr_en", 32'(rd_wr_en), 32'd0);
    check("rst_addr", 32'(rd_reg_address), 32'd0);
    check("rst_data", rd_reg_data, 32'd0);
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_req_addr", mem_req_addr, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
`ifdef SC_CORE_OZ_WB_MISALIGN_EN
    check("rst_misalign", 32'(misalign_err), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Directed scenarios
    alu_op(5'd5, 32'hDEAD_BEEF, 1'b1);
    alu_op(5'd0, 32'h1234_5678, 1'b1);
    alu_op(5'd7, 32'h0BAD_F00D, 1'b0);
    load_op(3'd0, 32'h0000_0103, 5'd9,  0, 1, 32'h8011_2233, 1'b0);
    load_op(3'd5, 32'h0000_0202, 5'd10, 0, 0, 32'hA5C3_0000, 1'b0);
    load_op(3'd1, 32'h0000_0202, 5'd11, 1, 2, 32'hA5C3_0000, 1'b0);
    load_op(3'd4, 32'h0000_0202, 5'd12, 0, 1, 32'hA5C3_0000, 1'b0);
    load_op(3'd2, 32'h0000_0400, 5'd13, 5, 1, 32'h1357_9BDF, 1'b1);
    load_op(3'd2, 32'h0000_0102, 5'd14, 0, 1, 32'hCAFE_BABE, 1'b0);
    load_op(3'd0, 32'h0000_0080, 5'd0,  1, 1, 32'h0000_00FF, 1'b0);

    // Reset asserted while waiting for the response
    alu_valid   = 1'b1;
    ld_req      = 1'b1;
    ld_funct3   = 3'd2;
    ld_addr     = 32'h0000_0500;
    alu_rd_addr = 5'd3;
    tick();
    idle_inputs();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    tick();
    check("mid_stall_wait", 32'(stall), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_wr_en", 32'(rd_wr_en), 32'd0);
    check("mid_rst_addr", 32'(rd_reg_address), 32'd0);
    check("mid_rst_data", rd_reg_data, 32'd0);
    check("mid_rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("mid_rst_req_addr", mem_req_addr, 32'd0);
    check("mid_rst_stall", 32'(stall), 32'd0);
    tick();
    rst = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h7777_7777;
    tick();
    mem_rsp_valid = 1'b0;
    check("late_rsp_wr_en", 32'(rd_wr_en), 32'd0);
    check("late_rsp_stall", 32'(stall), 32'd0);
    tick();
    check("late_rsp_wr_en2", 32'(rd_wr_en), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      if ($urandom_range(0, 2) == 0)
        alu_op(rd, $urandom, 1'($urandom_range(0, 3) != 0));
      else
        load_op(3'($urandom), $urandom, rd, $urandom_range(0, 4), $urandom_range(0, 3),
                $urandom, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
